// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter with CTS gating and busy timeout; define UART_ARB_LOCK_EN for packet lock
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 cts,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 error
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic cts_q, cts_s;
  logic [PW-1:0] rr_ptr, win, win_nxt;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] elig;
  logic found;
`ifdef UART_ARB_LOCK_EN
  logic locked, last_q;
  assign elig = locked ? (req_valid & grant) : req_valid;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign elig = req_valid;
`endif
  assign win_nxt = (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
  // scan downward so the last hit is the nearest eligible requester at or above rr_ptr
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (elig[(int'(rr_ptr) + i) % NUM_REQ]) begin
        win = PW'((int'(rr_ptr) + i) % NUM_REQ);
        found = 1'b1;
      end
  end
  // CTS synchronizer, arbitration FSM and registered outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cts_q <= 1'b1;
      cts_s <= 1'b1;
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      req_ready <= '0;
      grant <= '0;
      tx_data <= '0;
      tx_start <= 1'b0;
      error <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      locked <= 1'b0;
      last_q <= 1'b0;
`endif
    end else begin
      cts_q <= cts;
      cts_s <= cts_q;
      req_ready <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE:
          if (!cts_s && found) begin
            state <= LAUNCH;
            grant <= NUM_REQ'(1) << win;
            req_ready <= NUM_REQ'(1) << win;
            tx_start <= 1'b1;
            tx_data <= req_data[8*win +: 8];
`ifdef UART_ARB_LOCK_EN
            last_q <= req_last[win];
            if (!locked) rr_ptr <= win_nxt;
`else
            rr_ptr <= win_nxt;
`endif
          end
        LAUNCH: begin
          state <= WAIT_BUSY;
          cnt <= '0;
        end
        WAIT_BUSY:
          if (tx_busy) state <= WAIT_DONE;
          else if (cnt == CW'(BUSY_TIMEOUT-1)) begin
            error <= 1'b1;
            state <= IDLE;
            grant <= '0;
`ifdef UART_ARB_LOCK_EN
            locked <= 1'b0;
`endif
          end else cnt <= cnt + 1'b1;
        WAIT_DONE:
          if (!tx_busy) begin
            state <= IDLE;
`ifdef UART_ARB_LOCK_EN
            locked <= !last_q;
            if (last_q) grant <= '0;
`else
            grant <= '0;
`endif
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, CTS gating, busy timeout and reset
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TO = 16;
  logic clk = 1'b0, reset = 1'b0, cts = 1'b1, tx_busy = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_start, error;
  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .cts(cts),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .error(error)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [8:0] qm [N][16];
  int qh [N] = '{default: 0};
  int qt [N] = '{default: 0};
  int lg_idx [64], lg_dat [64], lg_rdy [64], lg_gnt [64], lg_cyc [64];
  int n_launch = 0;
  int t_ctr = -1;
  bit busy_en = 1'b1;
  int busy_dly = 2;
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction
  task automatic push(input int r, input int d, input bit last = 1'b1);
    qm[r][qt[r] % 16] = {last, 8'(d)};
    qt[r]++;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_launch(input int n, input int budget, input string tag);
    int k = 0;
    while (n_launch < n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, n_launch, n);
  endtask
  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((grant != 0 || tx_busy) && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, int'(grant), 0);
  endtask
  task automatic pulse_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(3);
  endtask
  // requesters pop on req_ready and present their next byte; transmitter model and launch log
  always @(negedge clk) begin
    for (int r = 0; r < N; r++) if (req_ready[r] && qh[r] != qt[r]) qh[r]++;
    for (int r = 0; r < N; r++) begin
      req_valid[r] = qh[r] != qt[r];
      req_data[8*r +: 8] = qm[r][qh[r] % 16][7:0];
      req_last[r] = qm[r][qh[r] % 16][8];
    end
    if (tx_start) begin
      if (n_launch < 64) begin
        lg_idx[n_launch] = oh_idx(grant);
        lg_gnt[n_launch] = int'(grant);
        lg_rdy[n_launch] = int'(req_ready);
        lg_dat[n_launch] = int'(tx_data);
        lg_cyc[n_launch] = cyc;
      end
      n_launch++;
      t_ctr = 0;
    end else if (t_ctr >= 0) t_ctr++;
    tx_busy = busy_en && t_ctr >= busy_dly && t_ctr < busy_dly + 10;
  end
  initial begin
    int base, c0, k;
    int exp_lock [4];
    tick(3);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_grant", int'(grant), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_error", int'(error), 0);
    @(negedge clk);
    reset = 1'b1;
    cts = 1'b0;
    tick(4);
    push(2, 8'h55);
    c0 = cyc;
    wait_launch(1, 20, "t1_launch");
    check("t1_data", lg_dat[0], 8'h55);
    check("t1_ready", lg_rdy[0], 4);
    check("t1_grant", lg_gnt[0], 4);
    check("t1_latency", lg_cyc[0] - c0, 1);
    check("t1_start_pulse", int'(tx_start), 0);
    check("t1_ready_pulse", int'(req_ready), 0);
    check("t1_grant_hold", int'(grant), 4);
    wait_idle(40, "t1_idle");
    check("t1_single", n_launch, 1);
    pulse_reset();
    base = n_launch;
    for (int r = 0; r < N; r++) begin
      push(r, 8'hA0 + r);
      push(r, 8'hA0 + r);
    end
    wait_launch(base + 8, 200, "t2_drain");
    for (int i = 0; i < 6; i++) begin
      check("t2_order", lg_idx[base + i], i % 4);
      check("t2_data", lg_dat[base + i], 8'hA0 + i % 4);
    end
    check("t2_b2b", lg_cyc[base + 1] - lg_cyc[base], 14);
    wait_idle(40, "t2_idle");
    cts = 1'b1;
    tick(3);
    push(1, 8'h3C);
    base = n_launch;
    tick(50);
    check("t3_blocked", n_launch, base);
    cts = 1'b0;
    c0 = cyc;
    wait_launch(base + 1, 20, "t3_launch");
    check("t3_cts_lat", lg_cyc[base] - c0, 3);
    cts = 1'b1;
    tick(3);
    check("t3_hold_data", int'(tx_data), 8'h3C);
    check("t3_hold_grant", int'(grant), 2);
    wait_idle(40, "t3_idle");
    check("t3_done", n_launch, base + 1);
    cts = 1'b0;
    tick(3);
    busy_dly = 16;
    base = n_launch;
    push(3, 8'h77);
    wait_launch(base + 1, 20, "t4_launch");
    wait_idle(60, "t4_idle");
    check("t4_no_err", int'(error), 0);
    busy_en = 1'b0;
    base = n_launch;
    push(3, 8'h78);
    wait_launch(base + 1, 20, "t5_launch");
    k = 0;
    while (!error && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5_err_time", cyc - lg_cyc[base], TO + 1);
    tick(1);
    check("t5_grant_clr", int'(grant), 0);
    busy_en = 1'b1;
    busy_dly = 2;
    base = n_launch;
    push(0, 8'h11);
    wait_launch(base + 1, 20, "t5_relaunch");
    check("t5_relaunch_data", lg_dat[base], 8'h11);
    check("t5_sticky", int'(error), 1);
    wait_idle(40, "t5_idle");
    pulse_reset();
    base = n_launch;
    push(0, 8'hE0);
    wait_launch(base + 1, 20, "t6_prime");
    wait_idle(40, "t6_prime_idle");
`ifdef UART_ARB_LOCK_EN
    exp_lock = '{1, 1, 1, 0};
`else
    exp_lock = '{1, 0, 1, 1};
`endif
    base = n_launch;
    push(0, 8'h0F);
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    wait_launch(base + 4, 200, "t6_drain");
    for (int i = 0; i < 4; i++) check("t6_order", lg_idx[base + i], exp_lock[i]);
    check("t6_first_data", lg_dat[base], 8'hB1);
    wait_idle(40, "t6_idle");
    base = n_launch;
    push(1, 8'hC1);
    push(1, 8'hC1);
    push(3, 8'hC3);
    push(3, 8'hC3);
    wait_launch(base + 1, 20, "t7_launch");
    tick(4);
    check("t7_in_byte", int'(grant != 0 && tx_busy), 1);
    reset = 1'b0;
    #1;
    check("t7_grant", int'(grant), 0);
    check("t7_tx_data", int'(tx_data), 0);
    check("t7_tx_start", int'(tx_start), 0);
    check("t7_req_ready", int'(req_ready), 0);
    check("t7_error", int'(error), 0);
    tick(2);
    reset = 1'b1;
    base = n_launch;
    wait_launch(base + 1, 40, "t7_relaunch");
    check("t7_lowest_first", lg_idx[base], 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART byte transmitter between `NUM_REQ` on-chip requesters. It arbitrates round-robin per byte, launches the transmitter with a single-cycle start pulse and tracks the transmitter's busy flag until the byte completes. It sits between producer logic and the UART TX datapath, honouring the far end's CTS flow control and flagging a transmitter that never responds.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 16: cycles allowed after `tx_start` for `tx_busy` to rise; minimum 2.
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: requester i has a byte pending.
- `req_data` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last` in NUM_REQ: byte ends requester i's packet (used only with lock feature).
- `req_ready` out NUM_REQ: one-hot single-cycle pulse, byte of requester i taken.
- `grant` out NUM_REQ: one-hot current owner, 0 when idle.
- `cts` in 1: far-end clear-to-send, active-low (0 = may send).
- `tx_data` out 8: byte to transmitter, held stable from `tx_start` until return to IDLE.
- `tx_start` out 1: single-cycle launch pulse.
- `tx_busy` in 1: transmitter shifting a byte.
- `error` out 1: sticky, transmitter failed to go busy.

## Operation
- `cts` passes through a 2-flop synchronizer (`cts_s`); it is reset to 1, meaning not clear.
- States:
  - IDLE: if `cts_s`==0 and any eligible `req_valid`, pick the winner and go to LAUNCH. Otherwise stay.
  - LAUNCH: one cycle, then WAIT_BUSY.
  - WAIT_BUSY: on `tx_busy`=1, go to WAIT_DONE. If the counter reaches BUSY_TIMEOUT-1 first, set `error` and go to IDLE.
  - WAIT_DONE: on `tx_busy`=0, go to IDLE.
- Winner selection: first requester with `req_valid`=1 scanning upward from `rr_ptr`, wrapping modulo NUM_REQ.
- `rr_ptr` becomes winner+1 (wrapping) at the IDLE→LAUNCH edge. `rr_ptr` resets to 0.
- On the IDLE→LAUNCH edge, register `grant`, `tx_data`=req_data[winner], `tx_start`=1 and `req_ready`=onehot(winner). All four are visible during LAUNCH.
- `req_data` is sampled at the end of the IDLE decision cycle. Requesters hold `req_valid`/`req_data` until they see `req_ready`, then may drop or change them in the next cycle.
- `grant` clears on entry to IDLE.
- CTS is checked only in IDLE. A byte already launched always completes even if `cts_s` rises.
- `error` is sticky until reset. It does not block further arbitration.
- Reset mid-operation: state IDLE; all outputs 0; `rr_ptr` 0; timeout counter 0; synchronizer 1.

## Timing
- Reset values: `req_ready`=0, `grant`=0, `tx_data`=0x00, `tx_start`=0, `error`=0.
- Request latency: `req_valid` high in cycle N (IDLE, `cts_s`=0) gives `tx_start`/`req_ready` high in N+1 only.
- CTS latency: `cts` falls in cycle N; earliest `tx_start` is in cycle N+3.
- Timeout: the counter starts at 0 in the first WAIT_BUSY cycle. `error` goes high BUSY_TIMEOUT+1 cycles after the `tx_start` cycle if `tx_busy` stays 0.
- Back-to-back: `tx_busy` seen low at the edge ending cycle M; IDLE in M+1; next `tx_start` in M+2.
- Simultaneous events: if `tx_busy` rises in the same cycle the count hits its limit, busy wins and no error is set.

## Configuration
- `UART_ARB_LOCK_EN` defined: packet lock.
  - After sending a byte with `req_last[w]`=0, `grant` stays at w through IDLE and only requester w is eligible.
  - Lock releases after a byte with `req_last[w]`=1 completes, or on timeout.
  - While locked, `rr_ptr` does not advance.
- `UART_ARB_LOCK_EN` undefined: pure per-byte round-robin, `req_last` ignored, `grant` clears in IDLE.

## Test plan
- Single byte: `req_valid`=0b0100, byte 0x55, `cts`=0, model raises busy 2 cycles after start for 10 cycles → one `tx_start` with `tx_data`=0x55, `req_ready`=0b0100 for 1 cycle, `grant`=0b0100 until IDLE.
- Fairness: all 4 valid continuously, distinct bytes 0xA0..0xA3 → launch order 0,1,2,3,0,1; no requester launched twice before all others.
- Flow control: `cts`=1 with requests pending for 50 cycles → no `tx_start`; drop `cts` → `tx_start` exactly 3 cycles later. Raise `cts` mid-byte → byte completes.
- Timeout: `tx_busy` tied 0 → `error`=1 exactly BUSY_TIMEOUT+1 cycles after `tx_start`. Next request is still launched and `error` stays 1.
- Lock (macro defined): requester 1 sends 3 bytes with `req_last`=0,0,1 while requester 0 is valid → order 1,1,1,0. With macro undefined → order 1,0,1,1.
- Reset: assert `reset`=0 during WAIT_DONE → all outputs 0 immediately. After release, the first launch serves the lowest-index valid requester.
